// File: rtl/mux_pkg.sv
// Shared definitions for the registered round-robin N:1 mux.
// Mode and output-register state encodings.
package mux_pkg;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: rotate requests by ptr,
// pick the lowest set bit, rotate the index back.
module rr_arbiter #(
  parameter  int N    = 8,
  localparam int SELW = $clog2(N)
) (
  input  logic [N-1:0]    req,
  input  logic [SELW-1:0] ptr,
  output logic [SELW-1:0] grant,
  output logic            grant_valid
);

  function automatic int wrapn(input int v);
    return (v >= N) ? v - N : v;
  endfunction

  logic [N-1:0]    rot;
  logic [SELW-1:0] idx;

  always_comb begin
    rot = '0;
    for (int i = 0; i < N; i++) begin
      rot[i] = req[wrapn(i + int'(ptr))];
    end
  end

  always_comb begin
    idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (rot[i]) idx = SELW'(i);
    end
  end

  assign grant_valid = |rot;
  assign grant = SELW'(wrapn(int'(idx) + int'(ptr)));

endmodule

// File: rtl/mux_rr_nx1.sv
// Registered N:1 mux with valid/ready per channel, fixed or
// round-robin selection, and a one-entry output register.
module mux_rr_nx1
  import mux_pkg::*;
#(
  parameter  int WIDTH = 32,
  parameter  int N     = 8,
  localparam int SELW  = $clog2(N)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             mode,
  input  logic [SELW-1:0]  S,
  input  logic [N*WIDTH-1:0] in_data,
  input  logic [N-1:0]     in_valid,
  output logic [N-1:0]     in_ready,
  output logic [WIDTH-1:0] Y,
  output logic             Y_valid,
  output logic [SELW-1:0]  Y_sel,
  input  logic             Y_ready
);

  localparam int PW = 1 << SELW;

  logic [WIDTH-1:0] ch [PW];
  logic [PW-1:0]    vpad;
  logic [SELW-1:0]  arb_grant;
  logic             arb_valid;
  logic             fix_valid;
  logic [SELW-1:0]  grant;
  logic             grant_valid;
  logic             load;

  state_e           state_q;
  logic [WIDTH-1:0] y_q;
  logic [SELW-1:0]  ysel_q;
  logic [SELW-1:0]  ptr_q;
  logic [SELW-1:0]  ptr_d;

  // Pad channels to a power of two so S >= N reads as idle.
  for (genvar i = 0; i < PW; i++) begin : g_ch
    if (i < N) begin : g_real
      assign ch[i] = in_data[i*WIDTH +: WIDTH];
    end else begin : g_pad
      assign ch[i] = '0;
    end
  end

  assign vpad = PW'(in_valid);
  assign fix_valid = vpad[S];

  rr_arbiter #(.N(N)) u_arb (
    .req         (in_valid),
    .ptr         (ptr_q),
    .grant       (arb_grant),
    .grant_valid (arb_valid)
  );

  always_comb begin
    grant       = S;
    grant_valid = fix_valid;
    if (mode == MODE_RR) begin
      grant       = arb_grant;
      grant_valid = arb_valid;
    end
  end

  assign Y_valid = (state_q == ST_FULL);
  assign Y       = y_q;
  assign Y_sel   = ysel_q;

  assign load = reset_n && grant_valid
              && (!Y_valid || Y_ready);

  assign in_ready = load ? (N'(1) << grant) : '0;

  always_comb begin
    ptr_d = ptr_q;
    if (load && mode == MODE_RR) begin
      if (grant == SELW'(N - 1)) ptr_d = '0;
      else ptr_d = grant + SELW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_EMPTY;
      y_q     <= '0;
      ysel_q  <= '0;
      ptr_q   <= '0;
    end else begin
      ptr_q <= ptr_d;
      unique case (state_q)
        ST_EMPTY: begin
          if (load) begin
            y_q     <= ch[grant];
            ysel_q  <= grant;
            state_q <= ST_FULL;
          end
        end
        ST_FULL: begin
          if (load) begin
            y_q    <= ch[grant];
            ysel_q <= grant;
          end else if (Y_ready) begin
            state_q <= ST_EMPTY;
          end
        end
        default: state_q <= ST_EMPTY;
      endcase
    end
  end

endmodule

// File: tb/tb_mux_rr_nx1.sv
// Bench for mux_rr_nx1: N=8 and N=5 instances checked against
// a cycle-level model of the selection rules.
module tb_mux_rr_nx1;

  logic clk;
  logic reset_n;

  logic        a_mode;
  logic [2:0]  a_S;
  logic [255:0] a_data;
  logic [7:0]  a_valid;
  logic [7:0]  a_ready;
  logic [31:0] a_Y;
  logic        a_Yv;
  logic [2:0]  a_Ysel;
  logic        a_Yr;

  logic        b_mode;
  logic [2:0]  b_S;
  logic [159:0] b_data;
  logic [4:0]  b_valid;
  logic [4:0]  b_ready;
  logic [31:0] b_Y;
  logic        b_Yv;
  logic [2:0]  b_Ysel;
  logic        b_Yr;

  int checks;
  int failures;

  bit          mv   [2];
  logic [31:0] my   [2];
  int          msel [2];
  int          mptr [2];

  mux_rr_nx1 #(.WIDTH(32), .N(8)) dut_a (
    .clk(clk), .reset_n(reset_n), .mode(a_mode), .S(a_S),
    .in_data(a_data), .in_valid(a_valid), .in_ready(a_ready),
    .Y(a_Y), .Y_valid(a_Yv), .Y_sel(a_Ysel), .Y_ready(a_Yr)
  );

  mux_rr_nx1 #(.WIDTH(32), .N(5)) dut_b (
    .clk(clk), .reset_n(reset_n), .mode(b_mode), .S(b_S),
    .in_data(b_data), .in_valid(b_valid), .in_ready(b_ready),
    .Y(b_Y), .Y_valid(b_Yv), .Y_sel(b_Ysel), .Y_ready(b_Yr)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      mv[d] = 1'b0; my[d] = '0; msel[d] = 0; mptr[d] = 0;
    end
  endtask

  // One clock on dut d; the other dut idles (no valid, no ready) so it holds.
  task automatic step(input int d, input logic md, input logic [2:0] s,
                      input logic [7:0] vin, input logic yr, input bit rnd);
    int n;
    int g;
    int idx;
    bit gv;
    bit full;
    bit ld;
    logic [7:0] v;
    logic [7:0] er;
    logic [7:0] ar;
    logic [31:0] dat [8];
    logic        ayv;
    logic [31:0] ay;
    logic [2:0]  asel;
    n = (d == 0) ? 8 : 5;
    v = vin;
    if (d == 1) v[7:5] = 3'b000;
    @(negedge clk);
    for (int i = 0; i < 8; i++) dat[i] = rnd ? $urandom : 32'hA0 + i;
    if (d == 0) begin
      a_mode = md; a_S = s; a_valid = v; a_Yr = yr;
      for (int i = 0; i < 8; i++) a_data[i*32 +: 32] = dat[i];
      b_valid = '0; b_Yr = 1'b0;
    end else begin
      b_mode = md; b_S = s; b_valid = v[4:0]; b_Yr = yr;
      for (int i = 0; i < 5; i++) b_data[i*32 +: 32] = dat[i];
      a_valid = '0; a_Yr = 1'b0;
    end
    gv = 1'b0;
    g  = 0;
    if (md == 1'b0) begin
      g  = int'(s);
      gv = (g < n) && v[s];
    end else begin
      for (int k = 0; k < n; k++) begin
        idx = (mptr[d] + k) % n;
        if (!gv && v[idx]) begin
          gv = 1'b1;
          g  = idx;
        end
      end
    end
    full = mv[d];
    ld   = gv && (!full || yr);
    er   = ld ? (8'd1 << g) : 8'd0;
    #1;
    ar = (d == 0) ? a_ready : {3'b000, b_ready};
    checks++;
    if (ar !== er) begin
      failures++;
      $display("FAIL in_ready dut%0d got %b want %b", d, ar, er);
    end
    @(posedge clk);
    if (ld) begin
      my[d] = dat[g]; msel[d] = g; mv[d] = 1'b1;
      if (md) mptr[d] = (g + 1) % n;
    end else if (full && yr) begin
      mv[d] = 1'b0;
    end
    #1;
    ayv  = (d == 0) ? a_Yv : b_Yv;
    ay   = (d == 0) ? a_Y : b_Y;
    asel = (d == 0) ? a_Ysel : b_Ysel;
    checks++;
    if (ayv !== mv[d]) begin
      failures++;
      $display("FAIL Y_valid dut%0d got %b want %b", d, ayv, mv[d]);
    end
    checks++;
    if (ay !== my[d]) begin
      failures++;
      $display("FAIL Y dut%0d got %h want %h", d, ay, my[d]);
    end
    checks++;
    if (asel !== 3'(msel[d])) begin
      failures++;
      $display("FAIL Y_sel dut%0d got %0d want %0d", d, asel, msel[d]);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    a_valid = 8'hFF; b_valid = 5'h1F; a_Yr = 1'b1; b_Yr = 1'b1;
    a_mode = 1'b1; b_mode = 1'b1;
    #1;
    checks++;
    if (a_ready !== 8'h00 || b_ready !== 5'h00) begin
      failures++;
      $display("FAIL reset_ready got %b %b want 0", a_ready, b_ready);
    end
    @(negedge clk);
    a_valid = '0; b_valid = '0;
    reset_n = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    do_reset();
    for (int i = 0; i < 5; i++) step(0, 1'b0, 3'd0, 8'h00, 1'b1, 1'b0);
    checks++;
    if (a_Y !== 32'h0 || a_Yv !== 1'b0) begin
      failures++;
      $display("FAIL reset_idle got Y=%h v=%b want 0", a_Y, a_Yv);
    end
  endtask

  task automatic test_fixed();
    for (int i = 0; i < 4; i++) begin
      step(0, 1'b0, 3'd3, 8'hFF, 1'b1, 1'b0);
      checks++;
      if (a_Y !== 32'hA3 || a_Ysel !== 3'd3) begin
        failures++;
        $display("FAIL fixed got %h/%0d want a3/3", a_Y, a_Ysel);
      end
    end
  endtask

  task automatic test_rr();
    do_reset();
    for (int k = 0; k < 9; k++) begin
      step(0, 1'b1, 3'd0, 8'hFF, 1'b1, 1'b0);
      checks++;
      if (a_Ysel !== 3'(k % 8) || a_Yv !== 1'b1) begin
        failures++;
        $display("FAIL rr_seq got %0d/%b want %0d/1", a_Ysel, a_Yv, k % 8);
      end
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    step(0, 1'b1, 3'd0, 8'h04, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step(0, 1'b1, 3'd0, 8'hFF, 1'b0, 1'b0);
      checks++;
      if (a_Y !== 32'hA2 || a_Yv !== 1'b1) begin
        failures++;
        $display("FAIL bp_hold got %h/%b want a2/1", a_Y, a_Yv);
      end
    end
    step(0, 1'b1, 3'd0, 8'hFF, 1'b1, 1'b0);
    checks++;
    if (a_Ysel !== 3'd3) begin
      failures++;
      $display("FAIL bp_next got %0d want 3", a_Ysel);
    end
  endtask

  task automatic test_sparse_wrap();
    do_reset();
    step(1, 1'b1, 3'd0, 8'h02, 1'b1, 1'b0);
    step(1, 1'b1, 3'd0, 8'h12, 1'b1, 1'b0);
    checks++;
    if (b_Ysel !== 3'd4) begin
      failures++;
      $display("FAIL wrap_first got %0d want 4", b_Ysel);
    end
    step(1, 1'b1, 3'd0, 8'h12, 1'b1, 1'b0);
    checks++;
    if (b_Ysel !== 3'd1) begin
      failures++;
      $display("FAIL wrap_second got %0d want 1", b_Ysel);
    end
    step(1, 1'b0, 3'd6, 8'h1F, 1'b1, 1'b0);
    step(1, 1'b0, 3'd6, 8'h1F, 1'b1, 1'b0);
    checks++;
    if (b_Yv !== 1'b0) begin
      failures++;
      $display("FAIL s_out_of_range got %b want 0", b_Yv);
    end
  endtask

  task automatic test_async_reset();
    step(0, 1'b1, 3'd0, 8'hFF, 1'b0, 1'b1);
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if (a_Yv !== 1'b0 || a_ready !== 8'h00) begin
      failures++;
      $display("FAIL async_reset got v=%b rdy=%b want 0", a_Yv, a_ready);
    end
    @(negedge clk);
    a_valid = '0; b_valid = '0;
    reset_n = 1'b1;
    model_reset();
    step(0, 1'b1, 3'd0, 8'hFF, 1'b1, 1'b0);
    checks++;
    if (a_Ysel !== 3'd0) begin
      failures++;
      $display("FAIL post_reset_grant got %0d want 0", a_Ysel);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      step(int'($urandom_range(1, 0)), 1'($urandom_range(1, 0)),
           3'($urandom_range(7, 0)), 8'($urandom),
           1'($urandom_range(3, 0) != 0), 1'b1);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset_n  = 1'b0;
    a_mode = 1'b0; a_S = '0; a_data = '0; a_valid = '0; a_Yr = 1'b0;
    b_mode = 1'b0; b_S = '0; b_data = '0; b_valid = '0; b_Yr = 1'b0;
    model_reset();
    test_reset();
    test_fixed();
    test_rr();
    test_backpressure();
    test_sparse_wrap();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
